// File: rtl/spi_rx_deserializer_pkg.sv
// Shared constants and state encoding for the SPI receive deserializer.
package spi_rx_deserializer_pkg;

   localparam int DATA_WIDTH_DEF = 32;

   // SPI mode 0, MSB first: sample MOSI on SCLK rising edge, SCLK idles low
   localparam bit CPOL      = 1'b0;
   localparam bit CPHA      = 1'b0;
   localparam bit MSB_FIRST = 1'b1;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2
   } rx_state_t;

endpackage

// File: rtl/spi_rx_deserializer_sync.sv
// Synchronises SCLK/SS/MOSI into clk domain and produces a registered SCLK rising-edge strobe.
module spi_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic SCLK,
   input  logic SS,
   input  logic MOSI,
   output logic ss_s,
   output logic mosi_s,
   output logic sclk_rise,
   output logic primed
);

   logic [SYNC_STAGES-1:0] sclk_q;
   logic [SYNC_STAGES-1:0] ss_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   sclk_prev;
   logic [SYNC_STAGES:0]   prime_q;

   // ss_s/mosi_s get one extra flop so they stay aligned with the registered sclk_rise.
   // primed marks when ss_s reflects the pin rather than its reset value.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sclk_q    <= '0;
         ss_q      <= '1;
         mosi_q    <= '0;
         sclk_prev <= 1'b0;
         sclk_rise <= 1'b0;
         ss_s      <= 1'b1;
         mosi_s    <= 1'b0;
         prime_q   <= '0;
      end else begin
         sclk_q    <= {sclk_q[SYNC_STAGES-2:0], SCLK};
         ss_q      <= {ss_q[SYNC_STAGES-2:0], SS};
         mosi_q    <= {mosi_q[SYNC_STAGES-2:0], MOSI};
         sclk_prev <= sclk_q[SYNC_STAGES-1];
         sclk_rise <= sclk_q[SYNC_STAGES-1] & ~sclk_prev;
         ss_s      <= ss_q[SYNC_STAGES-1];
         mosi_s    <= mosi_q[SYNC_STAGES-1];
         prime_q   <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign primed = prime_q[SYNC_STAGES];

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI mode-0 receiver: oversampled deserialiser feeding a first-word fall-through FIFO.
//
// state     | meaning
// WAIT_IDLE | after reset; ignore SPI activity until SS seen high
// IDLE      | SS high, waiting for frame start
// SHIFT     | frame in progress, capturing bits on SCLK rise
module spi_rx_deserializer
   import spi_rx_deserializer_pkg::*;
#(
   parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int FIFO_DEPTH_LOG2 = 2,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       SCLK,
   input  logic                       SS,
   input  logic                       MOSI,
   output logic [DATA_WIDTH-1:0]      rx_data,
   output logic                       rx_valid,
   input  logic                       rx_ready,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
   output logic                       busy,
   output logic                       overflow,
   output logic                       frame_err
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CNT_W = $clog2(DATA_WIDTH);

   logic ss_s, mosi_s, sclk_rise, primed;

   spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLK       (CLK),
      .RST       (RST),
      .SCLK      (SCLK),
      .SS        (SS),
      .MOSI      (MOSI),
      .ss_s      (ss_s),
      .mosi_s    (mosi_s),
      .sclk_rise (sclk_rise),
      .primed    (primed)
   );

   rx_state_t             state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] shift_next;
   logic                  word_done;

   // SS release has priority over a coincident SCLK edge
   always_comb begin
      shift_next = {shift_q[DATA_WIDTH-2:0], mosi_s};
      word_done  = (state == SHIFT) && !ss_s && sclk_rise && (bit_cnt == CNT_W'(DATA_WIDTH-1));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= WAIT_IDLE;
         bit_cnt   <= '0;
         shift_q   <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            WAIT_IDLE: if (primed && ss_s) state <= IDLE;
            IDLE: begin
               if (!ss_s) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               if (ss_s) begin
                  frame_err <= (bit_cnt != '0);
                  bit_cnt   <= '0;
                  state     <= IDLE;
               end else if (sclk_rise) begin
                  shift_q <= shift_next;
                  bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
               end
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end

   assign busy = (state == SHIFT);

   logic [DATA_WIDTH-1:0]    mem [DEPTH];
   logic [FIFO_DEPTH_LOG2:0] wr_ptr, rd_ptr;
   logic                     fifo_full, pop;

   assign fifo_level = wr_ptr - rd_ptr;
   assign fifo_full  = (fifo_level == (FIFO_DEPTH_LOG2+1)'(DEPTH));
   assign rx_valid   = (fifo_level != '0);
   assign rx_data    = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
   assign pop        = rx_valid && rx_ready;

   // When full, a simultaneous pop frees the slot the push lands in
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (word_done) begin
            if (!fifo_full || pop) begin
               mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= shift_next;
               wr_ptr <= wr_ptr + 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Directed bench for spi_rx_deserializer: SCLK = CLK/8, inputs driven on CLK negedge.
module tb_spi_rx_deserializer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        SCLK = 1'b0;
   logic        SS = 1'b1;
   logic        MOSI = 1'b0;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic [2:0]  fifo_level;
   logic        busy;
   logic        overflow;
   logic        frame_err;

   int n_checks = 0;
   int n_fail   = 0;
   int ovf_cnt  = 0;
   int ferr_cnt = 0;
   int busy_lo  = 0;
   bit busy_chk = 1'b0;
   logic [31:0] got_q [$];

   spi_rx_deserializer dut (
      .CLK        (CLK),
      .RST        (RST),
      .SCLK       (SCLK),
      .SS         (SS),
      .MOSI       (MOSI),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .fifo_level (fifo_level),
      .busy       (busy),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (overflow)  ovf_cnt++;
      if (frame_err) ferr_cnt++;
      if (busy_chk && !busy) busy_lo++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      MOSI = b;
      repeat (4) @(negedge CLK);
      SCLK = 1'b1;
      repeat (4) @(negedge CLK);
      SCLK = 1'b0;
   endtask

   // mode 0: plain; 1: check FIFO latency on last bit; 2: pulse rx_ready in the push cycle
   task automatic send_word(input logic [31:0] w, input int mode);
      for (int i = 31; i >= 1; i--) send_bit(w[i]);
      MOSI = w[0];
      repeat (4) @(negedge CLK);
      SCLK = 1'b1;
      repeat (3) @(negedge CLK);
      if (mode == 1) chk("lat_valid_early", rx_valid, 0);
      if (mode == 2) rx_ready = 1'b1;
      @(negedge CLK);
      if (mode == 1) begin
         chk("lat_valid", rx_valid, 1);
         chk("lat_data", rx_data, w);
      end
      if (mode == 2) rx_ready = 1'b0;
      repeat (4) @(negedge CLK);
      SCLK = 1'b0;
   endtask

   task automatic frame_begin();
      SS = 1'b0;
      repeat (8) @(negedge CLK);
   endtask

   task automatic frame_end();
      SS = 1'b1;
      repeat (8) @(negedge CLK);
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] exp);
      chk(tag, rx_data, exp);
      rx_ready = 1'b1;
      @(negedge CLK);
      rx_ready = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge CLK);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {overflow, frame_err}, 0);
      RST = 1'b0;
      repeat (6) @(negedge CLK);

      // single word with latency
      ovf_cnt = 0; ferr_cnt = 0;
      frame_begin();
      send_word(32'hA5C3_0F96, 1);
      frame_end();
      chk("single_level", fifo_level, 1);
      chk("single_data", rx_data, 32'hA5C3_0F96);
      chk("single_flags", ovf_cnt + ferr_cnt, 0);
      pop_chk("single_pop", 32'hA5C3_0F96);
      chk("single_empty", fifo_level, 0);

      // back-to-back words in one frame, consumer always ready
      got_q.delete();
      busy_lo = 0;
      rx_ready = 1'b1;
      frame_begin();
      busy_chk = 1'b1;
      send_word(32'h0000_0001, 0);
      send_word(32'hFFFF_FFFE, 0);
      repeat (6) @(negedge CLK);
      busy_chk = 1'b0;
      frame_end();
      rx_ready = 1'b0;
      chk("b2b_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("b2b_w0", got_q[0], 32'h0000_0001);
         chk("b2b_w1", got_q[1], 32'hFFFF_FFFE);
      end
      chk("b2b_busy", busy_lo, 0);
      chk("b2b_idle", busy, 0);

      // overflow on fifth word
      ovf_cnt = 0;
      frame_begin();
      for (int k = 1; k <= 5; k++) send_word(32'(k), 0);
      frame_end();
      chk("ovf_level", fifo_level, 4);
      chk("ovf_pulses", ovf_cnt, 1);
      for (int k = 1; k <= 4; k++) pop_chk("ovf_drain", 32'(k));
      chk("ovf_empty", fifo_level, 0);

      // push and pop together while full
      ovf_cnt = 0;
      frame_begin();
      for (int k = 1; k <= 4; k++) send_word(32'(k), 0);
      chk("fpp_full", fifo_level, 4);
      send_word(32'h5, 2);
      frame_end();
      chk("fpp_level", fifo_level, 4);
      chk("fpp_ovf", ovf_cnt, 0);
      for (int k = 2; k <= 5; k++) pop_chk("fpp_drain", 32'(k));

      // abort after 12 bits
      ferr_cnt = 0;
      frame_begin();
      for (int i = 11; i >= 0; i--) send_bit(i[0]);
      frame_end();
      chk("abort_ferr", ferr_cnt, 1);
      chk("abort_level", fifo_level, 0);
      frame_begin();
      send_word(32'hDEAD_BEEF, 0);
      frame_end();
      chk("abort_next_level", fifo_level, 1);
      chk("abort_next_data", rx_data, 32'hDEAD_BEEF);

      // reset mid-frame; DEADBEEF left in FIFO must be lost
      frame_begin();
      for (int i = 0; i < 20; i++) send_bit(1'b1);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk("mrst_outs", {rx_valid, busy, fifo_level}, 0);
      chk("mrst_data", rx_data, 0);
      RST = 1'b0;
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      repeat (4) @(negedge CLK);
      chk("mrst_ignored", {busy, fifo_level}, 0);
      frame_end();
      frame_begin();
      send_word(32'h1234_5678, 0);
      frame_end();
      chk("mrst_next_level", fifo_level, 1);
      chk("mrst_next_data", rx_data, 32'h1234_5678);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
